// File: rtl/s_machine_core_if.sv
// Data-memory handshake between s_machine_core (master) and the data RAM (slave).
// A request is held stable until the slave returns a one-cycle mem_ack.
interface s_machine_core_if #(
   parameter int DATA_W = 16,
   parameter int MEM_AW = 9
);
   logic              mem_req;
   logic              mem_we;
   logic [MEM_AW-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ack
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ack
   );
endinterface

// File: rtl/s_machine_core.sv
// S-Machine interpreter: 16-bit instructions, A/B accumulators of DATA_W bits,
// Z/N/C flags and a stalling load/store handshake to the data RAM.
module s_machine_core #(
   parameter int DATA_W = 16,
   parameter int PC_W   = 8,
   parameter int MEM_AW = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic [15:0]      inst,
   output logic [PC_W-1:0]  pc,
   s_machine_core_if.master mem,
   output logic             flag_z,
   output logic             flag_n,
   output logic             flag_c,
   output logic             busy,
   output logic             halted
);

   typedef enum logic [1:0] {ST_EXEC, ST_MEM_WAIT, ST_HALT} state_t;

   typedef enum logic [3:0] {
      OP_LD  = 4'h0, OP_ST   = 4'h1, OP_INC = 4'h2, OP_BRA  = 4'h3,
      OP_ADD = 4'h4, OP_SUB  = 4'h5, OP_OR  = 4'h6, OP_AND  = 4'h7,
      OP_XOR = 4'h8, OP_SHR  = 4'h9, OP_MOV = 4'hA, OP_EXCH = 4'hB,
      OP_CMP = 4'hC, OP_SET  = 4'hD, OP_CLR = 4'hE, OP_HALT = 4'hF
   } opcode_t;

   state_t              r_state, w_state_nxt;
   logic [PC_W-1:0]     r_pc, w_pc_nxt;
   logic [DATA_W-1:0]   r_a, w_a_nxt;
   logic [DATA_W-1:0]   r_b, w_b_nxt;
   logic                r_z, w_z_nxt;
   logic                r_n, w_n_nxt;
   logic                r_c, w_c_nxt;
   logic                r_mem_we, w_mem_we_nxt;
   logic [MEM_AW-1:0]   r_mem_addr, w_mem_addr_nxt;
   logic [DATA_W-1:0]   r_mem_wdata, w_mem_wdata_nxt;
   logic                r_ld_b, w_ld_b_nxt;

   opcode_t             w_op;
   logic [DATA_W-1:0]   w_src;
   logic [DATA_W-1:0]   w_imm_zx;
   logic [DATA_W-1:0]   w_imm_sx;
   logic [DATA_W:0]     w_sum;
   logic [DATA_W-1:0]   w_res;
   logic                w_zn_upd;
   logic                w_bra_taken;

   assign w_op        = opcode_t'(inst[15:12]);
   assign w_src       = inst[11] ? r_b : r_a;
   assign w_imm_zx    = {{(DATA_W-8){1'b0}}, inst[7:0]};
   assign w_imm_sx    = {{(DATA_W-8){inst[7]}}, inst[7:0]};
   assign w_bra_taken = (inst[10:8] == 3'b000) || ((inst[10:8] & {r_z, r_n, r_c}) != 3'b000);

   always_comb begin
      // NOTE: every next-state value gets a hold default first so no path through the case infers a latch.
      w_state_nxt     = r_state;
      w_pc_nxt        = r_pc;
      w_a_nxt         = r_a;
      w_b_nxt         = r_b;
      w_z_nxt         = r_z;
      w_n_nxt         = r_n;
      w_c_nxt         = r_c;
      w_mem_we_nxt    = r_mem_we;
      w_mem_addr_nxt  = r_mem_addr;
      w_mem_wdata_nxt = r_mem_wdata;
      w_ld_b_nxt      = r_ld_b;
      w_sum           = '0;
      w_res           = '0;
      w_zn_upd        = 1'b0;

      case (r_state)
         ST_EXEC: if (enable) begin
            w_pc_nxt = r_pc + PC_W'(1);
            case (w_op)
               OP_LD: begin
                  if (inst[10]) begin
                     w_res = inst[9] ? {inst[7:0], {(DATA_W-8){1'b0}}} : w_imm_zx;
                     if (inst[11]) w_b_nxt = w_res;
                     else          w_a_nxt = w_res;
                  end else begin
                     w_state_nxt    = ST_MEM_WAIT;
                     w_mem_we_nxt   = 1'b0;
                     w_mem_addr_nxt = MEM_AW'(inst[8:0]);
                     w_ld_b_nxt     = inst[11];
                  end
               end
               OP_ST: begin
                  w_state_nxt     = ST_MEM_WAIT;
                  w_mem_we_nxt    = 1'b1;
                  w_mem_addr_nxt  = MEM_AW'(inst[8:0]);
                  w_mem_wdata_nxt = w_src;
               end
               OP_INC: begin
                  w_sum    = {1'b0, w_src} + {1'b0, w_imm_sx};
                  w_res    = w_sum[DATA_W-1:0];
                  w_c_nxt  = w_sum[DATA_W];
                  w_zn_upd = 1'b1;
                  if (inst[11]) w_b_nxt = w_res;
                  else          w_a_nxt = w_res;
               end
               OP_BRA: if (w_bra_taken) w_pc_nxt = PC_W'(inst[7:0]);
               OP_ADD, OP_SUB, OP_CMP: begin
                  // The extra top bit is the carry for ADD and the borrow (A<B) for SUB/CMP.
                  w_sum    = (w_op == OP_ADD) ? ({1'b0, r_a} + {1'b0, r_b})
                                              : ({1'b0, r_a} - {1'b0, r_b});
                  w_res    = w_sum[DATA_W-1:0];
                  w_c_nxt  = w_sum[DATA_W];
                  w_zn_upd = 1'b1;
                  if (w_op != OP_CMP) w_a_nxt = w_res;
               end
               OP_OR, OP_AND, OP_XOR: begin
                  w_res    = (w_op == OP_OR)  ? (r_a | r_b) :
                             (w_op == OP_AND) ? (r_a & r_b) : (r_a ^ r_b);
                  w_c_nxt  = 1'b0;
                  w_zn_upd = 1'b1;
                  w_a_nxt  = w_res;
               end
               OP_SHR: begin
                  w_res    = r_a >> 1;
                  w_c_nxt  = r_a[0];
                  w_zn_upd = 1'b1;
                  w_a_nxt  = w_res;
               end
               OP_MOV: w_b_nxt = r_a;
               OP_EXCH: begin
                  w_a_nxt = r_b;
                  w_b_nxt = r_a;
               end
               OP_SET: begin
                  if (inst[10]) w_z_nxt = 1'b1;
                  if (inst[9])  w_n_nxt = 1'b1;
                  if (inst[8])  w_c_nxt = 1'b1;
               end
               OP_CLR: begin
                  if (inst[10]) w_z_nxt = 1'b0;
                  if (inst[9])  w_n_nxt = 1'b0;
                  if (inst[8])  w_c_nxt = 1'b0;
               end
               OP_HALT: begin
                  w_state_nxt = ST_HALT;
                  w_pc_nxt    = r_pc;
               end
               default: ;
            endcase
         end
         ST_MEM_WAIT: if (mem.mem_ack) begin
            w_state_nxt = ST_EXEC;
            if (!r_mem_we) begin
               if (r_ld_b) w_b_nxt = mem.mem_rdata;
               else        w_a_nxt = mem.mem_rdata;
            end
         end
         default: ;
      endcase

      if (w_zn_upd) begin
         w_z_nxt = (w_res == '0);
         w_n_nxt = w_res[DATA_W-1];
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         r_state     <= ST_EXEC;
         r_pc        <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_z         <= 1'b0;
         r_n         <= 1'b0;
         r_c         <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_ld_b      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_pc        <= w_pc_nxt;
         r_a         <= w_a_nxt;
         r_b         <= w_b_nxt;
         r_z         <= w_z_nxt;
         r_n         <= w_n_nxt;
         r_c         <= w_c_nxt;
         r_mem_we    <= w_mem_we_nxt;
         r_mem_addr  <= w_mem_addr_nxt;
         r_mem_wdata <= w_mem_wdata_nxt;
         r_ld_b      <= w_ld_b_nxt;
      end
   end

   // mem_req and busy are pure decodes of the state flop, so they fall on the same edge as the ack.
   assign mem.mem_req   = (r_state == ST_MEM_WAIT);
   assign mem.mem_we    = r_mem_we;
   assign mem.mem_addr  = r_mem_addr;
   assign mem.mem_wdata = r_mem_wdata;
   assign busy          = (r_state == ST_MEM_WAIT);
   assign halted        = (r_state == ST_HALT);
   assign pc            = r_pc;
   assign flag_z        = r_z;
   assign flag_n        = r_n;
   assign flag_c        = r_c;

endmodule

// File: tb/tb_s_machine_core.sv
// Directed bench for s_machine_core: 16-bit instance runs the main suite,
// a 32-bit instance checks the widened datapath.
module tb_s_machine_core;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic [15:0] inst;
   logic [7:0]  pc;
   logic        flag_z, flag_n, flag_c, busy, halted;

   logic        rst32;
   logic        en32;
   logic [15:0] inst32;
   logic [7:0]  pc32;
   logic        z32, n32, c32, busy32, halted32;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [7:0]  exp_pc   = 8'h00;

   always #5 clk = ~clk;

   s_machine_core_if #(.DATA_W(16), .MEM_AW(9)) mem16 ();
   s_machine_core_if #(.DATA_W(32), .MEM_AW(9)) mem32 ();

   s_machine_core #(.DATA_W(16), .PC_W(8), .MEM_AW(9)) dut (
      .clk(clk), .rst(rst), .enable(enable), .inst(inst), .pc(pc), .mem(mem16),
      .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .busy(busy), .halted(halted)
   );

   s_machine_core #(.DATA_W(32), .PC_W(8), .MEM_AW(9)) dut32 (
      .clk(clk), .rst(rst32), .enable(en32), .inst(inst32), .pc(pc32), .mem(mem32),
      .flag_z(z32), .flag_n(n32), .flag_c(c32), .busy(busy32), .halted(halted32)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Issue one instruction with enable for a single cycle, then check pc.
   task automatic exec_to(input logic [15:0] i, input logic [7:0] pc_exp);
      inst   = i;
      enable = 1'b1;
      @(posedge clk); #1;
      enable = 1'b0;
      inst   = 16'h0000;
      exp_pc = pc_exp;
      check($sformatf("pc after %h", i), pc, exp_pc);
   endtask

   task automatic exec(input logic [15:0] i);
      exec_to(i, exp_pc + 8'd1);
   endtask

   initial begin
      rst = 1'b1; enable = 1'b0; inst = 16'h0000;
      rst32 = 1'b1; en32 = 1'b0; inst32 = 16'h0000;
      mem16.mem_ack = 1'b0; mem16.mem_rdata = 16'h0000;
      mem32.mem_ack = 1'b0; mem32.mem_rdata = 32'h0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state
      check("rst pc", pc, 8'h00);
      check("rst flags", {flag_z, flag_n, flag_c}, 3'b000);
      check("rst busy/halt/req", {busy, halted, mem16.mem_req}, 3'b000);
      check("rst A", dut.r_a, 16'h0000);
      check("rst B", dut.r_b, 16'h0000);

      // LD immediates then SUB
      exec(16'h0405);
      exec(16'h0C03);
      exec(16'h5000);
      check("sub A", dut.r_a, 16'h0002);
      check("sub ZNC", {flag_z, flag_n, flag_c}, 3'b000);
      check("sub pc", pc, 8'h03);

      // High-form LD, ADD with carry out, then branches on flags
      exec(16'h06FF);
      check("ldhi A", dut.r_a, 16'hFF00);
      exec(16'h0E01);
      check("ldhi B", dut.r_b, 16'h0100);
      exec(16'h4000);
      check("add A", dut.r_a, 16'h0000);
      check("add ZNC", {flag_z, flag_n, flag_c}, 3'b101);
      exec_to(16'h3440, 8'h40);
      exec_to(16'h3280, 8'h41);
      check("bra keeps flags", {flag_z, flag_n, flag_c}, 3'b101);

      // Store with ack delayed three cycles; a HALT with enable must be ignored meanwhile
      exec(16'h0477);
      exec(16'h11A5);
      inst = 16'hF000; enable = 1'b1;
      for (int k = 0; k < 4; k++) begin
         check($sformatf("st req c%0d", k), {mem16.mem_req, busy, mem16.mem_we}, 3'b111);
         check($sformatf("st addr c%0d", k), mem16.mem_addr, 9'h1A5);
         check($sformatf("st wdata c%0d", k), mem16.mem_wdata, 16'h0077);
         if (k == 3) mem16.mem_ack = 1'b1;
         @(posedge clk); #1;
         mem16.mem_ack = 1'b0;
      end
      inst = 16'h0000; enable = 1'b0;
      check("st done req/busy", {mem16.mem_req, busy}, 2'b00);
      check("st pc held", pc, 8'h43);
      check("st not halted", halted, 1'b0);

      // Load into B with ack in the first wait cycle
      exec(16'h09A5);
      check("ld req/we", {mem16.mem_req, busy, mem16.mem_we}, 3'b110);
      check("ld addr", mem16.mem_addr, 9'h1A5);
      mem16.mem_ack = 1'b1; mem16.mem_rdata = 16'hBEEF;
      @(posedge clk); #1;
      mem16.mem_ack = 1'b0;
      check("ld B", dut.r_b, 16'hBEEF);
      check("ld done req/busy", {mem16.mem_req, busy}, 2'b00);
      check("ld keeps flags", {flag_z, flag_n, flag_c}, 3'b101);

      // Stray ack in EXEC is ignored
      mem16.mem_ack = 1'b1; mem16.mem_rdata = 16'h1234;
      @(posedge clk); #1;
      mem16.mem_ack = 1'b0;
      check("stray ack B", dut.r_b, 16'hBEEF);
      check("stray ack pc", pc, 8'h44);

      // INC boundaries, logic, compare, shift, exchange, move
      exec(16'h0400);
      exec(16'h20FF);
      check("inc-1 A", dut.r_a, 16'hFFFF);
      check("inc-1 ZNC", {flag_z, flag_n, flag_c}, 3'b010);
      exec(16'h2001);
      check("inc+1 A", dut.r_a, 16'h0000);
      check("inc+1 ZNC", {flag_z, flag_n, flag_c}, 3'b101);
      exec(16'h040F);
      exec(16'h0C3C);
      exec(16'h7000);
      check("and A", dut.r_a, 16'h000C);
      check("and ZNC", {flag_z, flag_n, flag_c}, 3'b000);
      exec(16'hC000);
      check("cmp A kept", dut.r_a, 16'h000C);
      check("cmp ZNC", {flag_z, flag_n, flag_c}, 3'b011);
      exec(16'h9000);
      check("shr A", dut.r_a, 16'h0006);
      check("shr ZNC", {flag_z, flag_n, flag_c}, 3'b000);
      exec(16'hB000);
      check("exch A", dut.r_a, 16'h003C);
      check("exch B", dut.r_b, 16'h0006);
      exec(16'hA000);
      check("mov B", dut.r_b, 16'h003C);
      exec(16'hD500);
      check("set Z,C", {flag_z, flag_n, flag_c}, 3'b101);
      exec(16'hE100);
      check("clr C", {flag_z, flag_n, flag_c}, 3'b100);

      // Stall at 0xFF, then wrap
      exec_to(16'h30FF, 8'hFF);
      for (int k = 0; k < 5; k++) begin
         inst = (k % 2 == 0) ? 16'h2005 : 16'hF000;
         @(posedge clk); #1;
         check($sformatf("stall pc c%0d", k), pc, 8'hFF);
      end
      check("stall A", dut.r_a, 16'h003C);
      exec_to(16'hA000, 8'h00);

      // Reset during MEM_WAIT, then a late ack
      exec(16'h11A5);
      @(posedge clk); #1;
      check("pre-rst req", mem16.mem_req, 1'b1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("rst mid req/busy", {mem16.mem_req, busy}, 2'b00);
      check("rst mid pc", pc, 8'h00);
      check("rst mid flags", {flag_z, flag_n, flag_c}, 3'b000);
      mem16.mem_ack = 1'b1; mem16.mem_rdata = 16'hDEAD;
      @(posedge clk); #1;
      mem16.mem_ack = 1'b0;
      check("late ack A", dut.r_a, 16'h0000);
      check("late ack B", dut.r_b, 16'h0000);
      check("late ack req", mem16.mem_req, 1'b0);
      exp_pc = 8'h00;

      // HALT freezes everything until reset
      exec_to(16'hF000, 8'h00);
      check("halted", halted, 1'b1);
      for (int k = 0; k < 4; k++) begin
         enable = k[0];
         inst   = (k < 2) ? 16'h0455 : 16'h3000;
         @(posedge clk); #1;
         check($sformatf("halt pc c%0d", k), pc, 8'h00);
         check($sformatf("halt flag c%0d", k), halted, 1'b1);
      end
      enable = 1'b0;
      check("halt A", dut.r_a, 16'h0000);

      // 32-bit datapath
      #1 rst32 = 1'b0;
      @(posedge clk); #1;
      inst32 = 16'h20FF; en32 = 1'b1;
      @(posedge clk); #1;
      check("w32 inc-1 A", dut32.r_a, 32'hFFFF_FFFF);
      check("w32 inc-1 ZNC", {z32, n32, c32}, 3'b010);
      check("w32 pc", pc32, 8'h01);
      inst32 = 16'h06FF;
      @(posedge clk); #1;
      en32 = 1'b0;
      check("w32 ldhi A", dut32.r_a, 32'hFF00_0000);
      check("w32 pc2", pc32, 8'h02);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
